// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: pipeline hazard unit with operand forwarding, load-use
// and multi-cycle (mul/div) interlocks, and optional performance counters.
// Optional feature macro: HAZ_PERF_CNT_EN enables the StallCnt/FlushCnt
// counters; without it both ports read constant zero.
module hazard_scoreboard #(
  parameter int REG_AW = 5,
  parameter int MD_LAT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] RdD,
  input  logic              RegWriteD,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic              ResultSrcE0,
  input  logic              MdStartE,
  input  logic              PCSrcE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              MdBusy,
  output logic              MdDone,
  output logic [REG_AW-1:0] MdRd,
  output logic [31:0]       StallCnt,
  output logic [31:0]       FlushCnt
);

  localparam int CW = $clog2(MD_LAT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mdState_e;

  mdState_e          state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [REG_AW-1:0] mdRd_q, mdRd_d;

  logic              issue;
  logic              pending;
  logic [REG_AW-1:0] pendRd;
  logic              lwStall;
  logic              mdRaw;
  logic              mdStruct;

  // Forwarding select: memory stage has priority over writeback; x0 never forwards
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (Rs1E != '0 && RegWriteM && Rs1E == RdM)      ForwardAE = 2'b10;
    else if (Rs1E != '0 && RegWriteW && Rs1E == RdW) ForwardAE = 2'b01;
    if (Rs2E != '0 && RegWriteM && Rs2E == RdM)      ForwardBE = 2'b10;
    else if (Rs2E != '0 && RegWriteW && Rs2E == RdW) ForwardBE = 2'b01;
  end

  // Hazard detection and the resulting stall/flush controls
  always_comb begin
    issue    = MdStartE && (state_q != BUSY);
    pending  = (state_q != IDLE) || issue;
    pendRd   = issue ? RdE : mdRd_q;
    lwStall  = ResultSrcE0 && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
    mdRaw    = pending && (pendRd != '0) &&
               ((Rs1D == pendRd) || (Rs2D == pendRd) || (RegWriteD && (RdD == pendRd)));
    mdStruct = MdStartE && (state_q == BUSY);
    StallE   = mdStruct;
    FlushM   = mdStruct;
    StallF   = lwStall || mdRaw || mdStruct;
    StallD   = StallF;
    FlushE   = (lwStall || mdRaw || PCSrcE) && !mdStruct;
    FlushD   = PCSrcE && !mdStruct;
    MdBusy   = (state_q != IDLE);
    MdDone   = (state_q == DONE);
    MdRd     = mdRd_q;
  end

  // Multi-cycle unit next state: a new issue always restarts the countdown
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mdRd_d  = mdRd_q;
    if (issue) begin
      state_d = BUSY;
      cnt_d   = CW'(MD_LAT - 2);
      mdRd_d  = RdE;
    end else begin
      case (state_q)
        BUSY: begin
          if (cnt_q == '0) state_d = DONE;
          else             cnt_d   = cnt_q - CW'(1);
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Multi-cycle unit state registers; reset drops any outstanding op
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mdRd_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mdRd_q  <= mdRd_d;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stallCnt_q;
  logic [31:0] flushCnt_q;

  // Free-running wrap-around counters of front-end stalls and taken branches
  always_ff @(posedge clk) begin
    if (reset) begin
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      if (StallF) stallCnt_q <= stallCnt_q + 32'd1;
      if (PCSrcE) flushCnt_q <= flushCnt_q + 32'd1;
    end
  end

  assign StallCnt = stallCnt_q;
  assign FlushCnt = flushCnt_q;
`else
  assign StallCnt = 32'd0;
  assign FlushCnt = 32'd0;
`endif

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter REG_AW, default 5: register-index width.
REQ-002 Parameter MD_LAT, default 4, legal >=2: cycles from multi-cycle (mul/div) issue to its result cycle.
REQ-003 One clock, `clk`; reset is synchronous and active-high on `reset`.
REQ-004 Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- Rs1D, Rs2D, RdD  in  REG_AW  decode-stage sources and destination
- RegWriteD  in  1  decode-stage instruction writes a register
- Rs1E, Rs2E, RdE  in  REG_AW  execute-stage sources and destination
- ResultSrcE0  in  1  execute-stage instruction is a load
- MdStartE  in  1  execute-stage instruction is a multi-cycle op
- PCSrcE  in  1  branch/jump taken in execute
- RdM, RdW  in  REG_AW  memory/writeback destinations
- RegWriteM, RegWriteW  in  1  memory/writeback write enables
- ForwardAE, ForwardBE  out  2  00 regfile, 10 from M, 01 from W
- StallF, StallD, StallE  out  1  hold stage register
- FlushD, FlushE, FlushM  out  1  clear stage register to bubble
- MdBusy  out  1  multi-cycle op outstanding
- MdDone  out  1  multi-cycle result writes MdRd this cycle
- MdRd  out  REG_AW  pending multi-cycle destination
- StallCnt, FlushCnt  out  32  performance counters

Function
REQ-005 ForwardAE SHALL be 10 if Rs1E==RdM, RegWriteM and Rs1E!=0; else 01 if Rs1E==RdW, RegWriteW and Rs1E!=0; else 00; ForwardBE identically with Rs2E; combinational.
REQ-006 lwStall SHALL be ResultSrcE0 & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
REQ-007 Multi-cycle FSM states: IDLE, BUSY, DONE; issue = MdStartE & state!=BUSY.
REQ-008 On issue, FSM SHALL capture RdE into MdRd, load counter with MD_LAT-2, and enter BUSY.
REQ-009 In BUSY, counter SHALL decrement each cycle; at count 0 the FSM SHALL enter DONE.
REQ-010 Issue at edge t SHALL yield BUSY for MD_LAT-1 cycles then exactly one DONE cycle; MdDone=1 only in DONE.
REQ-011 In DONE: issue SHALL go to BUSY (back-to-back); otherwise go to IDLE.
REQ-012 MdBusy SHALL be 1 in BUSY or DONE.
REQ-013 pending = MdBusy | issue; pendRd = issue ? RdE : MdRd.
REQ-014 mdRaw SHALL be pending & pendRd!=0 & (Rs1D==pendRd | Rs2D==pendRd | (RegWriteD & RdD==pendRd)).
REQ-015 mdStruct SHALL be MdStartE & state==BUSY.
REQ-016 StallE = FlushM = mdStruct.
REQ-017 StallF = StallD = lwStall | mdRaw | mdStruct.
REQ-018 FlushE = (lwStall | mdRaw | PCSrcE) & ~StallE; FlushD = PCSrcE & ~StallE.
REQ-019 StallE and FlushE SHALL never both be 1; PCSrcE with mdStruct is illegal stimulus, and stall then wins.

Reset
REQ-020 While reset is 1 at an edge, state SHALL become IDLE, counter 0, MdRd 0, StallCnt and FlushCnt 0.
REQ-021 Reset mid-BUSY SHALL discard the pending op; no MdDone pulse follows.
REQ-022 After reset, MdBusy=0, MdDone=0, StallE=0 and FlushM=0; the other outputs follow the inputs combinationally.

Configuration
REQ-023 Macro HAZ_PERF_CNT_EN defined: StallCnt SHALL increment (wrapping) each cycle StallF=1, and FlushCnt SHALL increment (wrapping) each cycle PCSrcE=1.
REQ-024 Macro HAZ_PERF_CNT_EN undefined: the ports SHALL remain, tied to constant 0, with no counter flops.

Verification
REQ-025 Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 -> ForwardAE=10; then RegWriteM=0 -> 01; then Rs1E=0 -> 00.
REQ-026 Load with RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle; with RdE=0 -> no stall.
REQ-027 MD_LAT=4, issue RdE=9 at t, Rs1D=9 from t -> StallD=1 t..t+4, MdDone=1 only at t+4, StallD=0 at t+5.
REQ-028 Second MdStartE during BUSY -> StallE=FlushM=1, FlushE=0 until DONE, then accepted; MdRd updates at that edge.
REQ-029 reset=1 during BUSY -> next cycle MdBusy=0, no MdDone, counters 0.
REQ-030 With HAZ_PERF_CNT_EN: 3 stall cycles plus 2 taken branches -> StallCnt=3, FlushCnt=2; without the macro both stay 0.
